fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, giving the PC fetched first after reset.
REQ-002 SHALL have parameter DEPTH, default 4, giving the instruction-queue entries; legal values are powers of two, 2..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port imem_en, output, 1 bit: instruction-memory read request this cycle.
REQ-006 SHALL have port imem_addr, output, 14 bits: word address, equal to request PC[15:2].
REQ-007 SHALL have port imem_rdata, input, 32 bits: read data, valid exactly one cycle after imem_en.
REQ-008 SHALL have port redirect, input, 1 bit: branch/jump taken in decode; flush and refetch.
REQ-009 SHALL have port redirect_pc, input, 64 bits: target PC when redirect=1.
REQ-010 SHALL have port out_valid, output, 1 bit: the queue head holds a valid instruction.
REQ-011 SHALL have port out_ready, input, 1 bit: decode accepts the head (driven by ~StallD).
REQ-012 SHALL have port out_instr, output, 32 bits: head instruction, or 32'h00000013 (NOP) when out_valid=0.
REQ-013 SHALL have port out_pc, output, 64 bits: PC of the head instruction, or 0 when out_valid=0.

Function
REQ-014 SHALL pop the head on the rising edge when out_valid and out_ready are both 1; out_* SHALL be driven combinationally from the head entry.
REQ-015 SHALL issue a request (imem_en=1) only when count + inflight < DEPTH, where inflight (0/1) means a request was issued in the previous cycle and is not cancelled.
REQ-016 SHALL drive imem_addr from fetch_pc, or from redirect_pc[15:2] in a redirect cycle; on each issue, fetch_pc SHALL advance by 4, or become redirect_pc+4 in a redirect cycle.
REQ-017 SHALL push {req_pc, imem_rdata} into the queue on the edge ending the response cycle, unless the response is cancelled.
REQ-018 A redirect in cycle t SHALL empty the queue, cancel any response arriving in cycle t, issue the request to redirect_pc in cycle t, and make the target instruction valid at out_* in cycle t+2.
REQ-019 Redirect SHALL take priority over a simultaneous push or pop; a pop in the redirect cycle is discarded.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; the queue SHALL never overflow or underflow.
REQ-021 Pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide; PC arithmetic SHALL be 64-bit and wrap without carry-out.
REQ-022 With out_ready held 0, the block SHALL fill the queue to DEPTH and then hold imem_en=0 until a pop.

Reset
REQ-023 While reset=0: queue empty, inflight=0, fetch_pc=RESET_PC, imem_en=0, out_valid=0, out_instr=NOP, out_pc=0.
REQ-024 Reset asserted mid-operation SHALL discard the queue and any in-flight response immediately; the response SHALL never be pushed.
REQ-025 The first request SHALL be issued in the first cycle after reset deasserts, at RESET_PC.

Structure
REQ-026 Constants SHALL reside in the shared riscv_pkg package: NOP encoding 32'h00000013, instruction width 32, XLEN 64.
REQ-027 The queue SHALL be implemented as a sub-module fetch_fifo (storage, pointers, count, flush); fetch_unit SHALL contain the PC, request, and cancel logic.

Verification
REQ-028 Reset release with RESET_PC=0, memory word i = i, out_ready=1 -> imem_addr 0,1,2... on consecutive cycles; out_pc 0,4,8 and out_instr 0,1,2 on consecutive cycles from the 3rd cycle after release.
REQ-029 out_ready=0 for 10 cycles -> exactly 4 requests issued, count=4, imem_en=0 afterwards; on release, 4 pops then streaming resumes with no lost or duplicated PC.
REQ-030 redirect=1, redirect_pc=0x100 in cycle t with the queue holding 3 entries and a response in flight -> cycle t+1 out_valid=0; cycle t+2 out_pc=0x100; old entries and the response never appear.
REQ-031 Back-to-back redirects to 0x200 then 0x300 -> only 0x300 and its successors appear at out_pc.
REQ-032 reset=0 pulsed mid-stream -> outputs reach REQ-023 values without waiting for an edge; refetch restarts at RESET_PC.
REQ-033 Random out_ready and redirect for 10k cycles against a reference PC model -> out_pc sequence matches, no overflow assertion fires.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants and types.
//   XLEN / ILEN     : register and instruction widths
//   NOP             : canonical nop encoding (addi x0, x0, 0)
//   fetch_entry_t   : one instruction-queue entry {pc, instr}
//   pc_to_word()    : byte PC -> 14-bit instruction-memory word address
package riscv_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned IMEM_AW = 14;

  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [IMEM_AW-1:0] pc_to_word(input logic [XLEN-1:0] pc);
    return pc[IMEM_AW+1:2];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decode-side handshake of the fetch unit (queue head towards decode).
//   valid : head entry holds a valid instruction
//   ready : consumer accepts the head this cycle
//   instr : head instruction (NOP when not valid)
//   pc    : head PC (0 when not valid)
// master = producer (instruction queue), slave = consumer (decode).
interface fetch_unit_if;
  import riscv_pkg::*;

  logic            valid;
  logic            ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);

endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue of the fetch unit: DEPTH-entry circular buffer.
//   clk, reset : clock, asynchronous active-low reset
//   flush      : empty the queue; wins over a simultaneous push/pop
//   push       : write push_data at the tail
//   push_data  : {pc, instr} entry
//   count      : number of valid entries (log2(DEPTH)+1 bits)
//   deq        : head entry and its valid/ready handshake
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  output logic [PW:0]  count,
  fetch_unit_if.master deq
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          pop;

  assign deq.valid = (count != '0);
  assign pop       = deq.valid & deq.ready;

  always_comb begin
    deq.instr = NOP;
    deq.pc    = '0;
    if (deq.valid) begin
      deq.instr = mem[rd_ptr].instr;
      deq.pc    = mem[rd_ptr].pc;
    end
  end

  // DEPTH is a power of two, so the pointers wrap on their natural width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC generation, instruction-memory requests,
// redirect/cancel handling, and a DEPTH-entry queue towards decode.
//   clk, reset           : clock, asynchronous active-low reset
//   imem_en / imem_addr  : memory read request and word address
//   imem_rdata           : read data, one cycle after imem_en
//   redirect/redirect_pc : flush and refetch from redirect_pc
//   out_valid/out_ready  : head handshake towards decode
//   out_instr / out_pc   : head instruction and its PC
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 64'h0,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [ILEN-1:0]     imem_rdata,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ILEN-1:0]     out_instr,
  output logic [XLEN-1:0]     out_pc
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] issue_pc;
  logic            inflight;
  logic [PW:0]     count;
  logic [PW+1:0]   occupancy;
  logic            push;
  fetch_entry_t    push_data;

  fetch_unit_if deq_if ();

  assign occupancy = {1'b0, count} + {{(PW+1){1'b0}}, inflight};
  assign issue_pc  = redirect ? redirect_pc : fetch_pc;

  // The queue and inflight clear asynchronously, which alone would make the
  // issue condition true during reset; gating with reset keeps imem_en low.
  // A redirect always issues: the flush and cancel free every slot.
  assign imem_en   = reset & (redirect | (occupancy < (PW+2)'(DEPTH)));
  assign imem_addr = pc_to_word(issue_pc);

  // The response arriving in a redirect cycle belongs to the old path.
  assign push      = inflight & ~redirect;
  assign push_data = '{pc: req_pc, instr: imem_rdata};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_en;
      if (imem_en) begin
        req_pc   <= issue_pc;
        fetch_pc <= issue_pc + XLEN'(4);
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .count     (count),
    .deq       (deq_if.master)
  );

  assign deq_if.ready = out_ready;
  assign out_valid    = deq_if.valid;
  assign out_instr    = deq_if.instr;
  assign out_pc       = deq_if.pc;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned     DEPTH    = 4;
  localparam logic [63:0]     RESET_PC = 64'h0;

  logic        clk         = 1'b0;
  logic        reset       = 1'b0;
  logic        redirect    = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata  = 32'h0;

  fetch_unit_if dec_if ();

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  logic [63:0] exp_q [$];
  logic [63:0] exp_next = RESET_PC;
  logic [63:0] e;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (dec_if.valid),
    .out_ready   (dec_if.ready),
    .out_instr   (dec_if.instr),
    .out_pc      (dec_if.pc)
  );

  // Instruction memory: word i holds the value i, one-cycle read latency.
  always @(posedge clk) imem_rdata <= imem_en ? {18'd0, imem_addr} : 32'hDEAD_BEEF;

  // Scoreboard: the reference PC stream restarts at RESET_PC after reset and
  // at redirect_pc after a redirect, then advances by 4 per accepted instruction.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      exp_next = RESET_PC;
    end else begin
      if (!dec_if.valid) begin
        n_checks++;
        if (dec_if.instr !== NOP || dec_if.pc !== 64'h0) begin
          n_fail++;
          $display("FAIL idle_outputs: got instr=%h pc=%h, expected instr=%h pc=0",
                   dec_if.instr, dec_if.pc, NOP);
        end
      end
      if (dec_if.valid && dec_if.ready && !redirect) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back(exp_next);
          exp_next = exp_next + 64'd4;
        end
        e = exp_q.pop_front();
        n_pops++;
        n_checks++;
        if (dec_if.pc !== e || dec_if.instr !== {18'd0, e[15:2]}) begin
          n_fail++;
          $display("FAIL sb_stream: got pc=%h instr=%h, expected pc=%h instr=%h",
                   dec_if.pc, dec_if.instr, e, {18'd0, e[15:2]});
        end
      end
      if (redirect) begin
        exp_q.delete();
        exp_next = redirect_pc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; dec_if.ready = 1'b1; redirect = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (imem_en !== 1'b0) begin n_fail++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
    n_checks++;
    if (dec_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dec_if.valid); end
    n_checks++;
    if (dec_if.instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000013", dec_if.instr); end
    n_checks++;
    if (dec_if.pc !== 64'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", dec_if.pc); end
    tick();
  endtask

  task automatic test_stream();
    reset = 1'b1; dec_if.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (imem_en !== 1'b1 || imem_addr !== 14'(k)) begin
        n_fail++;
        $display("FAIL stream_req k=%0d: got en=%b addr=%h, expected en=1 addr=%h", k, imem_en, imem_addr, 14'(k));
      end
      n_checks++;
      if (k >= 2) begin
        if (dec_if.valid !== 1'b1 || dec_if.pc !== 64'(4*(k-2)) || dec_if.instr !== 32'(k-2)) begin
          n_fail++;
          $display("FAIL stream_out k=%0d: got v=%b pc=%h instr=%h, expected v=1 pc=%h instr=%h",
                   k, dec_if.valid, dec_if.pc, dec_if.instr, 64'(4*(k-2)), 32'(k-2));
        end
      end else if (dec_if.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_latency k=%0d: got valid=%b expected 0", k, dec_if.valid);
      end
      tick();
    end
  endtask

  task automatic test_stall_fill();
    int reqs;
    reqs = 0;
    reset = 1'b0; dec_if.ready = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_en === 1'b1) reqs++;
      if (k >= 4) begin
        n_checks++;
        if (imem_en !== 1'b0) begin n_fail++; $display("FAIL fill_hold k=%0d: got imem_en=%b expected 0", k, imem_en); end
      end
      tick();
    end
    n_checks++;
    if (reqs != 4) begin n_fail++; $display("FAIL fill_requests: got %0d expected 4", reqs); end
    @(negedge clk);
    n_checks++;
    if (dec_if.valid !== 1'b1 || dec_if.pc !== RESET_PC) begin
      n_fail++; $display("FAIL fill_head: got v=%b pc=%h expected v=1 pc=%h", dec_if.valid, dec_if.pc, RESET_PC);
    end
    tick();
    dec_if.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_checks++;
      if (dec_if.valid !== 1'b1 || dec_if.pc !== 64'(4*k)) begin
        n_fail++; $display("FAIL drain k=%0d: got v=%b pc=%h expected v=1 pc=%h", k, dec_if.valid, dec_if.pc, 64'(4*k));
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    reset = 1'b0; dec_if.ready = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 64'h100;
    @(negedge clk);
    n_checks++;
    if (dec_if.valid !== 1'b1 || dec_if.pc !== 64'h0) begin
      n_fail++; $display("FAIL redir_pre_head: got v=%b pc=%h expected v=1 pc=0", dec_if.valid, dec_if.pc);
    end
    n_checks++;
    if (imem_en !== 1'b1 || imem_addr !== 14'h40) begin
      n_fail++; $display("FAIL redir_req: got en=%b addr=%h expected en=1 addr=40", imem_en, imem_addr);
    end
    tick();
    redirect = 1'b0; dec_if.ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dec_if.valid !== 1'b0) begin n_fail++; $display("FAIL redir_t1: got valid=%b expected 0", dec_if.valid); end
    tick();
    @(negedge clk);
    n_checks++;
    if (dec_if.valid !== 1'b1 || dec_if.pc !== 64'h100 || dec_if.instr !== 32'h40) begin
      n_fail++; $display("FAIL redir_t2: got v=%b pc=%h instr=%h expected v=1 pc=100 instr=40",
                         dec_if.valid, dec_if.pc, dec_if.instr);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (dec_if.valid !== 1'b1 || dec_if.pc !== 64'h104) begin
      n_fail++; $display("FAIL redir_t3: got v=%b pc=%h expected v=1 pc=104", dec_if.valid, dec_if.pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    dec_if.ready = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 64'h200;
    tick();
    redirect_pc = 64'h300;
    @(negedge clk);
    n_checks++;
    if (imem_en !== 1'b1 || imem_addr !== 14'hC0) begin
      n_fail++; $display("FAIL b2b_req: got en=%b addr=%h expected en=1 addr=c0", imem_en, imem_addr);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dec_if.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble: got valid=%b expected 0", dec_if.valid); end
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (dec_if.valid !== 1'b1 || dec_if.pc !== 64'h300 + 64'(4*k)) begin
        n_fail++; $display("FAIL b2b_stream k=%0d: got v=%b pc=%h expected v=1 pc=%h",
                           k, dec_if.valid, dec_if.pc, 64'h300 + 64'(4*k));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    dec_if.ready = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (imem_en !== 1'b0 || dec_if.valid !== 1'b0 || dec_if.instr !== 32'h0000_0013 || dec_if.pc !== 64'h0) begin
      n_fail++; $display("FAIL async_reset: got en=%b v=%b instr=%h pc=%h expected en=0 v=0 instr=00000013 pc=0",
                         imem_en, dec_if.valid, dec_if.instr, dec_if.pc);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if (imem_en !== 1'b1 || imem_addr !== RESET_PC[15:2]) begin
          n_fail++; $display("FAIL restart_req: got en=%b addr=%h expected en=1 addr=%h", imem_en, imem_addr, RESET_PC[15:2]);
        end
      end
      if (k == 2) begin
        n_checks++;
        if (dec_if.valid !== 1'b1 || dec_if.pc !== RESET_PC) begin
          n_fail++; $display("FAIL restart_out: got v=%b pc=%h expected v=1 pc=%h", dec_if.valid, dec_if.pc, RESET_PC);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    int pops_before;
    int waited;
    pops_before = n_pops;
    for (int c = 0; c < 10000; c++) begin
      dec_if.ready = ($urandom_range(0, 9) < 7);
      redirect     = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      else                           redirect_pc = {$urandom, $urandom} & ~64'h3;
      tick();
    end
    redirect = 1'b0; dec_if.ready = 1'b1;
    n_checks++;
    if (n_pops - pops_before < 3000) begin
      n_fail++; $display("FAIL random_throughput: got %0d pops expected at least 3000", n_pops - pops_before);
    end
    waited = 0;
    while (dec_if.valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    n_checks++;
    if (dec_if.valid !== 1'b1) begin
      n_fail++; $display("FAIL random_liveness: got valid=%b after %0d cycles expected 1", dec_if.valid, waited);
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
